// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution result writer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NUM_TAPS   = 9;
    localparam int unsigned CENTER_TAP = 4;

    // Nine products of DataBitWidth+CoefBitWidth+1 bits cannot overflow this width.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned coef_w);
        return data_w + coef_w + 5;
    endfunction

    // The identity kernel has unity gain once the Shift is applied.
    function automatic int identity_coef(input int unsigned tap, input int unsigned shift);
        return (tap == CENTER_TAP) ? (1 << shift) : 0;
    endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Window sample stream in and output RAM write port out.
interface conv_result_writer_if #(
    parameter int unsigned AddressBitWidth = 17,
    parameter int unsigned DataBitWidth    = 12
) ();

    logic                       valid_in;
    logic [DataBitWidth-1:0]    d_in;
    logic                       we;
    logic [AddressBitWidth-1:0] WriteAddress;
    logic [DataBitWidth-1:0]    d_out;

    modport master (
        output valid_in, d_in,
        input  we, WriteAddress, d_out
    );

    modport slave (
        input  valid_in, d_in,
        output we, WriteAddress, d_out
    );

endinterface

// File: rtl/conv_shift_sat.sv
// Arithmetic right shift of the signed accumulator, clamped to the unsigned pixel range.
module conv_shift_sat #(
    parameter int unsigned AccBitWidth  = 25,
    parameter int unsigned DataBitWidth = 12,
    parameter int unsigned Shift        = 4
) (
    input  logic signed [AccBitWidth-1:0] sum,
    output logic        [DataBitWidth-1:0] result
);

    localparam logic signed [AccBitWidth-1:0] MAX_VAL = AccBitWidth'((1 << DataBitWidth) - 1);

    logic signed [AccBitWidth-1:0] shifted;

    always_comb begin
        shifted = sum >>> Shift;
        if (shifted[AccBitWidth-1]) begin
            result = '0;
        end else if (shifted > MAX_VAL) begin
            result = '1;
        end else begin
            result = shifted[DataBitWidth-1:0];
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Multiplies each 3x3 window sample by its coefficient, accumulates nine taps,
// and writes the shifted, saturated result to sequential output RAM addresses.
module conv_result_writer
    import conv_pkg::*;
#(
    parameter int unsigned AddressBitWidth = 17,
    parameter int unsigned DataBitWidth    = 12,
    parameter int unsigned CoefBitWidth    = 8,
    parameter int unsigned Shift           = 4,
    parameter int unsigned NoOfRows        = 5,
    parameter int unsigned NoOfColumns     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           coef_we,
    input  logic [3:0]                     coef_addr,
    input  logic signed [CoefBitWidth-1:0] coef_in,
    output logic                           ready,
    conv_result_writer_if.slave            bus
);

    localparam int unsigned PW     = DataBitWidth + CoefBitWidth + 1;
    localparam int unsigned AW     = acc_width(DataBitWidth, CoefBitWidth);
    localparam int unsigned PIXELS = NoOfRows * NoOfColumns;
    localparam logic [3:0]  LAST_TAP = 4'(NUM_TAPS - 1);

    state_t state, state_next;

    logic signed [CoefBitWidth-1:0] coef [NUM_TAPS];
    logic [3:0]                     tap;
    logic signed [PW-1:0]           prod, din_ext, coef_ext;
    logic                           p_valid, p_last;
    logic signed [AW-1:0]           acc, sum;
    logic [AddressBitWidth-1:0]     pix_cnt;
    logic [DataBitWidth-1:0]        sat;
    logic                           accept, launch, write_now, final_write;

    always_comb begin
        accept      = (state == RUN) && bus.valid_in;
        launch      = (state != RUN) && start;
        write_now   = (state == RUN) && p_valid && p_last;
        final_write = write_now && (pix_cnt == AddressBitWidth'(PIXELS - 1));
        din_ext     = PW'($signed({1'b0, bus.d_in}));
        coef_ext    = PW'(coef[tap]);
        sum         = acc + AW'(prod);
    end

    conv_shift_sat #(
        .AccBitWidth (AW),
        .DataBitWidth(DataBitWidth),
        .Shift       (Shift)
    ) u_shift_sat (
        .sum   (sum),
        .result(sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (final_write) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap              <= '0;
            acc              <= '0;
            prod             <= '0;
            pix_cnt          <= '0;
            p_valid          <= 1'b0;
            p_last           <= 1'b0;
            ready            <= 1'b0;
            bus.we           <= 1'b0;
            bus.WriteAddress <= '0;
            bus.d_out        <= '0;
            for (int unsigned i = 0; i < NUM_TAPS; i++) begin
                coef[i] <= CoefBitWidth'(identity_coef(i, Shift));
            end
        end else begin
            bus.we  <= 1'b0;
            p_valid <= accept;
            p_last  <= accept && (tap == LAST_TAP);
            if (accept) begin
                prod <= din_ext * coef_ext;
                tap  <= (tap == LAST_TAP) ? '0 : tap + 4'd1;
            end
            if (bus.we) begin
                bus.WriteAddress <= bus.WriteAddress + 1'b1;
            end
            // Launch overrides the post-write address bump of a final write.
            if (launch) begin
                tap              <= '0;
                acc              <= '0;
                pix_cnt          <= '0;
                p_valid          <= 1'b0;
                ready            <= 1'b0;
                bus.WriteAddress <= '0;
            end else if (write_now) begin
                bus.d_out <= sat;
                bus.we    <= 1'b1;
                acc       <= '0;
                pix_cnt   <= pix_cnt + 1'b1;
                if (final_write) begin
                    ready <= 1'b1;
                end
            end else if ((state == RUN) && p_valid) begin
                acc <= sum;
            end
            if ((state != RUN) && coef_we && (coef_addr < 4'(NUM_TAPS))) begin
                coef[coef_addr] <= coef_in;
            end
        end
    end

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
- Consumer end of the 3x3 window stream produced by the conv2d window reader.
- Receives 9 zero-padded window samples per output pixel, multiplies each by a programmable 3x3 coefficient, and accumulates, shifts and saturates the sum.
- Writes the result to the output image RAM at sequential write addresses and raises ready when the full frame is written.

Parameters:
AddressBitWidth, 17, output RAM address width
DataBitWidth, 12, pixel width (unsigned in and out)
CoefBitWidth, 8, signed coefficient width
Shift, 4, arithmetic right shift applied to the accumulated sum
NoOfRows, 5, image rows
NoOfColumns, 5, image columns

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin frame (from IDLE or DONE)
valid_in  in  1  d_in carries a window sample this cycle
d_in  in  DataBitWidth  window sample (already zero-padded upstream)
coef_we  in  1  coefficient write strobe
coef_addr  in  4  tap index 0..8; 9..15 ignored
coef_in  in  CoefBitWidth  signed coefficient
we  out  1  output RAM write enable, one-cycle pulse
WriteAddress  out  AddressBitWidth  output RAM address
d_out  out  DataBitWidth  result pixel
ready  out  1  frame complete

Behaviour:
- Reset: state=IDLE; we=0, WriteAddress=0, d_out=0, ready=0.
  - tap=0, accumulator=0, pixel count=0, pipeline valid flags=0.
  - Coefficients reset to identity: tap 4 = 1<<Shift, all others 0.
  - Reset mid-frame aborts the frame with no further writes.
- Tap order within a window is column-major, tap = 3*colOffset + rowOffset, matching the upstream stream.
- States:
  - IDLE: start -> RUN.
  - RUN: accepts samples. After the write of pixel NoOfRows*NoOfColumns-1, go to DONE.
  - DONE: ready=1. start -> RUN with ready<=0.
- On entering RUN: tap, accumulator, pixel count and WriteAddress are cleared.
- valid_in is ignored outside RUN. The tap counter advances only on valid_in, so idle gaps between samples are allowed.
- Coefficient writes take effect in IDLE/DONE only; coef_we in RUN is ignored.
- Pipeline and latency:
  - Stage 1: at edge n, the product d_in*coef[tap] is registered (d_in zero-extended, signed multiply, width DataBitWidth+CoefBitWidth+1).
  - Stage 2: at edge n+1, acc+product goes into the accumulator. If that sample was tap 8:
    - the sum is arithmetic-shifted right by Shift,
    - then saturated to [0, 2^DataBitWidth-1],
    - and registered to d_out with we<=1;
    - the accumulator is cleared in the same cycle.
  - Net latency: tap-8 sample valid in cycle n -> we high in cycle n+2 for exactly one cycle.
- Accumulator width is DataBitWidth+CoefBitWidth+5 bits, signed; no overflow is possible for 9 taps.
- WriteAddress holds the address of the current write while we=1. It increments by 1 on the cycle after each write, so writes use 0,1,2,…
- Back-to-back windows with continuous valid_in are sustained at 1 sample/cycle, 1 result per 9 cycles.
- Final write and DONE: on the final write, state->DONE and ready=1 in the same cycle as that write's we. Samples arriving after it are ignored.
- start while in RUN is ignored.
- d_out holds its last value when we=0.

Decomposition:
- Shared package conv_pkg:
  - state encodings IDLE/RUN/DONE,
  - NUM_TAPS=9, CENTER_TAP=4,
  - accumulator width function,
  - default identity kernel.
- One sub-module, conv_shift_sat: combinational arithmetic shift plus clamp of the signed sum to the unsigned DataBitWidth range. All sequential logic stays in conv_result_writer.

Test Plan:
- Identity kernel: reset, start, stream a 5x5 ramp (pixel = 5r+c) as windows with zero padding. Expect 25 writes, addresses 0..24 with d_out 0..24, and ready=1 on the write to address 24.
- Box kernel: all coefficients 16, every sample 100. Expect d_out=900 per write, each we exactly 2 cycles after the tap-8 sample.
- Saturation, positive: all coefficients 127, samples 4095 -> d_out=4095.
- Saturation, negative: tap 4 = -16, others 0, center sample 50 -> d_out=0.
- Gaps and ignored inputs: random 0–3 cycle gaps in valid_in give identical results to the continuous stream. coef_we during RUN leaves the results unchanged.
- Reset and restart:
  - Assert rst after 40 samples -> no further writes, WriteAddress=0, kernel back to identity.
  - Then start from DONE after a full frame -> ready drops, addresses restart at 0.
